alu_op_issue: RTL and testbench

//  Decode stage that sits in front of the ALU. It accepts RV32I instructions with their register operands.
//  It decodes opcode/funct3/funct7 into the 4-bit ALU op code and selects the A and B operands.
//  It registers the result behind a valid/ready handshake, using a 2-entry skid buffer so instr_ready_o never depends combinationally on op_ready_i.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_decode.sv | 114 +++++++++++
 rtl/alu_op_issue.sv | 107 ++++++++++
 tb/tb_alu_op_issue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and the decoded request
// payload used by the ALU issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  funct3;
        logic        illegal;
    } alu_req_t;

    // funct3 mapping for the funct7=0 register/immediate arithmetic group
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: instruction, PC and register operands to an
// ALU request. Illegal encodings collapse to ADD 0,0 with the flag set.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output alu_req_t    req_o
);

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] i_imm_s;
    logic [31:0] s_imm_s;
    logic [31:0] u_imm_s;
    logic [31:0] shamt_s;
    alu_op_e     op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        illegal_s;

    assign opcode_s = instr_i[6:0];
    assign f3_s     = instr_i[14:12];
    assign f7_s     = instr_i[31:25];
    assign i_imm_s  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign s_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign u_imm_s  = {instr_i[31:12], 12'd0};
    assign shamt_s  = {27'd0, instr_i[24:20]};

    // opcode class decode and operand selection
    always_comb begin
        op_s      = ALU_ADD;
        a_s       = 32'd0;
        b_s       = 32'd0;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                a_s = rs1_data_i;
                b_s = rs2_data_i;
                if (f7_s == 7'b0000000) begin
                    op_s = f3_to_op(f3_s);
                end else if ((f7_s == 7'b0100000) && (f3_s == 3'b000)) begin
                    op_s = ALU_SUB;
                end else if ((f7_s == 7'b0100000) && (f3_s == 3'b101)) begin
                    op_s = ALU_SRA;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a_s  = rs1_data_i;
                op_s = f3_to_op(f3_s);
                // shift immediates carry the funct7 field in imm[11:5]
                if (f3_s == 3'b001) begin
                    b_s       = shamt_s;
                    illegal_s = (f7_s != 7'b0000000);
                end else if (f3_s == 3'b101) begin
                    b_s = shamt_s;
                    if (f7_s == 7'b0000000) begin
                        op_s = ALU_SRL;
                    end else if (f7_s == 7'b0100000) begin
                        op_s = ALU_SRA;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    b_s = i_imm_s;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                a_s = rs1_data_i;
                b_s = i_imm_s;
            end
            OPC_STORE: begin
                a_s = rs1_data_i;
                b_s = s_imm_s;
            end
            OPC_BRANCH: begin
                a_s = rs1_data_i;
                b_s = rs2_data_i;
                case (f3_s)
                    3'b000, 3'b001: op_s = ALU_SUB;
                    3'b100, 3'b101: op_s = ALU_SLT;
                    3'b110, 3'b111: op_s = ALU_SLTU;
                    default:        illegal_s = 1'b1;
                endcase
            end
            OPC_LUI: begin
                b_s = u_imm_s;
            end
            OPC_AUIPC: begin
                a_s = pc_i;
                b_s = u_imm_s;
            end
            OPC_JAL: begin
                a_s = pc_i;
                b_s = 32'd4;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign req_o.op      = illegal_s ? ALU_ADD : op_s;
    assign req_o.a       = illegal_s ? 32'd0 : a_s;
    assign req_o.b       = illegal_s ? 32'd0 : b_s;
    assign req_o.funct3  = f3_s;
    assign req_o.illegal = illegal_s;

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decode plus a registered output behind valid/ready, with an
// optional skid entry so instr_ready_o never depends on op_ready_i.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    output logic [3:0]      alu_control_op_o,
    output logic [XLEN-1:0] a_num_o,
    output logic [XLEN-1:0] b_num_o,
    output logic [2:0]      funct3_o,
    output logic            illegal_o
);

    alu_req_t dec_s;
    alu_req_t out_r;
    alu_req_t out_nxt_s;
    alu_req_t skid_r;
    alu_req_t skid_nxt_s;
    logic     out_valid_r;
    logic     out_valid_nxt_s;
    logic     skid_valid_r;
    logic     skid_valid_nxt_s;
    logic     accept_s;
    logic     drain_s;

    alu_issue_decode u_decode (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .req_o      (dec_s)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            assign instr_ready_o = ~skid_valid_r & ~rst_i;
        end else begin : g_no_skid
            assign instr_ready_o = (op_ready_i | ~out_valid_r) & ~rst_i;
        end
    endgenerate

    assign accept_s = instr_valid_i & instr_ready_o;
    assign drain_s  = out_valid_r & op_ready_i;

    // next state of the output and skid entries; skid refills output first for FIFO order
    always_comb begin
        out_nxt_s        = out_r;
        out_valid_nxt_s  = out_valid_r;
        skid_nxt_s       = skid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (skid_valid_r) begin
            if (drain_s) begin
                out_nxt_s        = skid_r;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = 1'b1;
            end
        end else if (accept_s) begin
            if (~out_valid_r | drain_s) begin
                out_nxt_s       = dec_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                skid_nxt_s       = dec_s;
                skid_valid_nxt_s = 1'b1;
            end
        end else if (drain_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // state registers, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_r        <= '0;
            out_valid_r  <= 1'b0;
            skid_r       <= '0;
            skid_valid_r <= 1'b0;
        end else begin
            out_r        <= out_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_r       <= skid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    assign op_valid_o       = out_valid_r;
    assign alu_control_op_o = out_r.op;
    assign a_num_o          = out_r.a;
    assign b_num_o          = out_r.b;
    assign funct3_o         = out_r.funct3;
    assign illegal_o        = out_r.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue: decode vectors, back-pressure,
// streaming and reset flush.
module tb_alu_op_issue;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  alu_op;
    logic [31:0] a_num;
    logic [31:0] b_num;
    logic [2:0]  funct3;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_op_issue #(.XLEN(32), .SKID_EN(1)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .instr_valid_i    (instr_valid),
        .instr_ready_o    (instr_ready),
        .instr_i          (instr),
        .pc_i             (pc),
        .rs1_data_i       (rs1),
        .rs2_data_i       (rs2),
        .op_valid_o       (op_valid),
        .op_ready_i       (op_ready),
        .alu_control_op_o (alu_op),
        .a_num_o          (a_num),
        .b_num_o          (b_num),
        .funct3_o         (funct3),
        .illegal_o        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one instruction for a single edge, then sample at the next negedge
    task automatic send(input logic [31:0] ins, input logic [31:0] pcv,
                        input logic [31:0] r1, input logic [31:0] r2);
        instr       = ins;
        pc          = pcv;
        rs1         = r1;
        rs2         = r2;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic ill);
        check({tag, "_valid"}, 32'(op_valid), 32'd1);
        check({tag, "_op"}, 32'(alu_op), 32'(op));
        check({tag, "_a"}, a_num, a);
        check({tag, "_b"}, b_num, b);
        check({tag, "_illegal"}, 32'(illegal), 32'(ill));
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; op_ready = 1'b0;
        instr = 32'd0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(op_valid), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_a", a_num, 32'd0);
        check("rst_op", 32'(alu_op), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(instr_ready), 32'd1);

        op_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check_op("add", 4'b0010, 32'd5, 32'd7, 1'b0);
        send(32'h402081B3, 32'h0, 32'd9, 32'd4);
        check_op("sub", 4'b0110, 32'd9, 32'd4, 1'b0);
        send(32'h4030D093, 32'h0, 32'h80000000, 32'd0);
        check_op("srai", 4'b0111, 32'h80000000, 32'd3, 1'b0);
        send(32'h4230D093, 32'h0, 32'h80000000, 32'd0);
        check_op("srai_bad", 4'b0010, 32'd0, 32'd0, 1'b1);
        send(32'h00208063, 32'h0, 32'd1, 32'd2);
        check_op("beq", 4'b0110, 32'd1, 32'd2, 1'b0);
        check("beq_f3", 32'(funct3), 32'd0);
        send(32'h0020E063, 32'h0, 32'd1, 32'd2);
        check_op("bltu", 4'b1010, 32'd1, 32'd2, 1'b0);
        check("bltu_f3", 32'(funct3), 32'd6);
        send(32'h0020A063, 32'h0, 32'd1, 32'd2);
        check_op("br_f3_010", 4'b0010, 32'd0, 32'd0, 1'b1);
        send(32'hFFC12083, 32'h0, 32'h1000, 32'd0);
        check_op("lw", 4'b0010, 32'h1000, 32'hFFFFFFFC, 1'b0);
        send(32'h0020A423, 32'h0, 32'h2000, 32'd3);
        check_op("sw", 4'b0010, 32'h2000, 32'd8, 1'b0);
        send(32'h12345037, 32'h40, 32'd77, 32'd0);
        check_op("lui", 4'b0010, 32'd0, 32'h12345000, 1'b0);
        send(32'h12345017, 32'h100, 32'd77, 32'd0);
        check_op("auipc", 4'b0010, 32'h100, 32'h12345000, 1'b0);
        send(32'h0000006F, 32'h200, 32'd77, 32'd0);
        check_op("jal", 4'b0010, 32'h200, 32'd4, 1'b0);
        send(32'h0000007F, 32'h0, 32'd1, 32'd1);
        check_op("bad_opc", 4'b0010, 32'd0, 32'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("idle_valid", 32'(op_valid), 32'd0);

        // back-pressure: two held, third stalls, then released in order
        op_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd11, 32'd0);
        check("bp_ready1", 32'(instr_ready), 32'd1);
        send(32'h002081B3, 32'h0, 32'd22, 32'd0);
        check("bp_ready2", 32'(instr_ready), 32'd0);
        instr = 32'h002081B3; rs1 = 32'd33; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_a", a_num, 32'd11);
        check("bp_hold_ready", 32'(instr_ready), 32'd0);
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_out2_a", a_num, 32'd22);
        check("bp_out2_valid", 32'(op_valid), 32'd1);
        check("bp_out2_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("bp_out3_a", a_num, 32'd33);
        check("bp_out3_valid", 32'(op_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_empty", 32'(op_valid), 32'd0);

        // streaming: one result per cycle, no bubbles
        instr = 32'h002081B3;
        for (int i = 0; i < 16; i++) begin
            rs1 = 32'd100 + 32'(i);
            instr_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("stream_valid", 32'(op_valid), 32'd1);
            check("stream_a", a_num, 32'd100 + 32'(i));
            check("stream_ready", 32'(instr_ready), 32'd1);
        end
        instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // reset flush with output and skid both full
        op_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd44, 32'd0);
        send(32'h002081B3, 32'h0, 32'd55, 32'd0);
        check("flush_full_ready", 32'(instr_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("flush_rst_ready", 32'(instr_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("flush_valid", 32'(op_valid), 32'd0);
        check("flush_a", a_num, 32'd0);
        #1;
        check("flush_ready", 32'(instr_ready), 32'd1);
        op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("flush_no_ghost", 32'(op_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
